axi_reg_cfg_seq: RTL and testbench
==================================

// Module: axi_reg_cfg_seq
// PURPOSE
// AXI4 master-side configuration sequencer for the AXI register block.
// On start: walks a parameter table of (address, data) entries; issues one single-beat write per entry, then one read-back; compares the read data.
// Reports done/err. Sits between local control logic and the register block's AXI slave port.
// PARAMETERS
// DATA_WIDTH   32                    data bus width (only 32 supported)
// ADDR_WIDTH   32                    byte address width
// NUM_ENTRIES  4                     table depth, 1..16
// CFG_ADDR     {32'hC,32'h8,32'h4,0} packed byte addresses, entry 0 in LSBs
// CFG_DATA     {32'h4,32'h3,32'h2,1} packed write data, entry 0 in LSBs
// TIMEOUT      16                    max wait cycles per handshake phase, >=1
// PORTS
// clk        in   1   clock, all logic on rising edge
// areset     in   1   asynchronous reset, active-high
// start_i    in   1   begin sequence; sampled only in IDLE
// busy_o     out  1   high from start accept until done
// done_o     out  1   one-cycle pulse at end of sequence, pass or fail
// err_o      out  1   sticky fail flag, cleared on next accepted start
// err_code_o out  2   00 ok, 01 bresp!=OKAY, 10 readback mismatch, 11 timeout
// err_idx_o  out  4   table index of the failing entry
// awaddr_o   out  AW  write address = CFG_ADDR entry
// awvalid_o  out  1   write address valid
// awready_i  in   1   write address ready
// wdata_o    out  DW  write data = CFG_DATA entry
// wstrb_o    out  4   constant 4'hF
// wlast_o    out  1   constant 1 (single-beat bursts)
// wvalid_o   out  1   write data valid
// wready_i   in   1   write data ready
// bresp_i    in   2   write response
// bvalid_i   in   1   write response valid
// bready_o   out  1   write response ready
// araddr_o   out  AW  read address = same entry address
// arvalid_o  out  1   read address valid
// arready_i  in   1   read address ready
// rdata_i    in   DW  read data
// rvalid_i   in   1   read data valid
// rready_o   out  1   read data ready
// BEHAVIOUR
// Reset: all outputs 0. FSM enters IDLE, index=0, timeout counter=0.
// - Reset is asynchronous and applies immediately, including mid-transaction; the slave sees valids drop in the same cycle.
// Transaction fixing: awlen=0, awsize=2, awburst=INCR are implied; no ID ports; one outstanding transaction.
// FSM states:
// - IDLE: start_i=1 -> WR; busy=1, err=0, err_code=0, index=0.
// - WR: awvalid and wvalid both asserted the first cycle in WR.
//   - Each valid drops independently after its own handshake.
//   - When both handshakes have occurred -> B.
//   - Handshakes may complete in either order or in the same cycle.
// - B: bready=1. On bvalid:
//   - bresp!=00: abort, code 01.
//   - bresp==00: -> AR.
// - AR: arvalid=1 until arready -> R.
// - R: rready=1. On rvalid:
//   - rdata!=CFG_DATA entry: abort, code 10.
//   - Match, index==NUM_ENTRIES-1: -> DONE.
//   - Match otherwise: index+1, -> WR.
// - DONE: done=1 for one cycle, busy=0, -> IDLE.
// - Abort: err=1, err_idx=index, -> DONE.
// Timeout: counter clears on every state entry and increments each cycle in WR/B/AR/R.
// - Reaching TIMEOUT aborts with code 11 and drops all valids/readies.
// Valid stability: all AXI valids stay high with stable payload until their handshake; never combinationally dependent on the slave's ready.
// Latency: zero-wait slave gives 1 WR + 1 B + 1 AR + 1 R = 4 cycles per entry.
// - Slave registered responses add their own latency.
// start_i outside IDLE is ignored. No bvalid/rvalid is expected outside B/R; if one arrives there it is ignored.
// STRUCTURE
// Package axi_reg_pkg holds: resp_e (OKAY=00, EXOKAY=01, SLVERR=10, DECERR=11), seq_err_e codes, state enum.
// No sub-module: a single FSM, index counter and timeout counter.
// TESTING
// 1. Default table, always-ready register block: start -> writes/reads 0x0..0xC with data 1..4.
//    - Expect done after 16+ cycles, err=0, register contents 1,2,3,4.
// 2. Entry 2 addr=0x18 (beyond 6 regs): slave returns bresp=10 -> done, err=1, code 01, idx 2; entries 0,1 written.
// 3. Slave rdata forced to 0xDEAD on entry 1 -> code 10, idx 1, no write to entry 2.
// 4. awready held low 20 cycles, TIMEOUT=16 -> abort on the 16th WR cycle with code 11; awvalid low afterward.
// 5. Skewed readiness: wready on cycle 1, awready on cycle 3 -> each valid drops after its own handshake; B entered after cycle 3.
// 6. areset pulsed in R of entry 1 -> all outputs 0 asynchronously; a new start runs the full table cleanly.
//    - start pulsed while busy -> ignored.

Source files
------------

// File: rtl/axi_reg_pkg.sv
// Shared types for the AXI register configuration sequencer:
// AXI response codes, sequencer error codes and FSM states.
package axi_reg_pkg;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } resp_e;

  typedef enum logic [1:0] {
    SEQ_OK       = 2'b00,
    SEQ_BRESP    = 2'b01,
    SEQ_MISMATCH = 2'b10,
    SEQ_TIMEOUT  = 2'b11
  } seq_err_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR,
    ST_B,
    ST_AR,
    ST_R,
    ST_DONE
  } state_e;

  localparam logic [3:0] WSTRB_FULL = 4'hF;

endpackage

// File: rtl/axi_reg_cfg_seq.sv
// AXI4 master that writes a constant (address, data) table into a register
// block, reading each entry back after its write, and reports done/err.
module axi_reg_cfg_seq
  import axi_reg_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int NUM_ENTRIES = 4,
  parameter logic [NUM_ENTRIES*ADDR_WIDTH-1:0] CFG_ADDR = {32'hC, 32'h8, 32'h4, 32'h0},
  parameter logic [NUM_ENTRIES*DATA_WIDTH-1:0] CFG_DATA = {32'h4, 32'h3, 32'h2, 32'h1},
  parameter int TIMEOUT     = 16
) (
  input  logic                  clk,
  input  logic                  areset,
  input  logic                  start_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o,
  output logic [1:0]            err_code_o,
  output logic [3:0]            err_idx_o,
  output logic [ADDR_WIDTH-1:0] awaddr_o,
  output logic                  awvalid_o,
  input  logic                  awready_i,
  output logic [DATA_WIDTH-1:0] wdata_o,
  output logic [3:0]            wstrb_o,
  output logic                  wlast_o,
  output logic                  wvalid_o,
  input  logic                  wready_i,
  input  logic [1:0]            bresp_i,
  input  logic                  bvalid_i,
  output logic                  bready_o,
  output logic [ADDR_WIDTH-1:0] araddr_o,
  output logic                  arvalid_o,
  input  logic                  arready_i,
  input  logic [DATA_WIDTH-1:0] rdata_i,
  input  logic                  rvalid_i,
  output logic                  rready_o
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
  localparam logic [3:0]    IDX_LAST = 4'(NUM_ENTRIES - 1);

  // Table is padded to 16 slots so a 4-bit index never reads out of range.
  logic [ADDR_WIDTH-1:0] addr_tbl [16];
  logic [DATA_WIDTH-1:0] data_tbl [16];

  for (genvar gi = 0; gi < 16; gi++) begin : g_tbl
    if (gi < NUM_ENTRIES) begin : g_used
      assign addr_tbl[gi] = CFG_ADDR[gi*ADDR_WIDTH +: ADDR_WIDTH];
      assign data_tbl[gi] = CFG_DATA[gi*DATA_WIDTH +: DATA_WIDTH];
    end else begin : g_unused
      assign addr_tbl[gi] = '0;
      assign data_tbl[gi] = '0;
    end
  end

  state_e                state_q;
  logic [3:0]            idx_q, idx_d;
  logic [TW-1:0]         tmo_q, tmo_d;
  logic                  busy_q, done_q, err_q;
  seq_err_e              err_code_q;
  logic [3:0]            err_idx_q;
  logic                  awvalid_q, wvalid_q, bready_q, arvalid_q, rready_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;

  logic     aw_done_d, w_done_d, tmo_hit;
  logic     abort_d;
  seq_err_e code_d;

  assign idx_d     = idx_q + 4'd1;
  assign tmo_d     = tmo_q + TW'(1);
  assign tmo_hit   = (tmo_q == TMO_LAST);
  // A channel counts as complete once its valid has dropped or it fires now.
  assign aw_done_d = !awvalid_q || awready_i;
  assign w_done_d  = !wvalid_q || wready_i;

  always_comb begin
    abort_d = 1'b0;
    code_d  = SEQ_OK;
    case (state_q)
      ST_WR: if (!(aw_done_d && w_done_d) && tmo_hit) begin
        abort_d = 1'b1;
        code_d  = SEQ_TIMEOUT;
      end
      ST_B: begin
        if (bvalid_i) begin
          if (resp_e'(bresp_i) != RESP_OKAY) begin
            abort_d = 1'b1;
            code_d  = SEQ_BRESP;
          end
        end else if (tmo_hit) begin
          abort_d = 1'b1;
          code_d  = SEQ_TIMEOUT;
        end
      end
      ST_AR: if (!arready_i && tmo_hit) begin
        abort_d = 1'b1;
        code_d  = SEQ_TIMEOUT;
      end
      ST_R: begin
        if (rvalid_i) begin
          if (rdata_i != data_tbl[idx_q]) begin
            abort_d = 1'b1;
            code_d  = SEQ_MISMATCH;
          end
        end else if (tmo_hit) begin
          abort_d = 1'b1;
          code_d  = SEQ_TIMEOUT;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      tmo_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      err_code_q <= SEQ_OK;
      err_idx_q  <= '0;
      awvalid_q  <= 1'b0;
      wvalid_q   <= 1'b0;
      bready_q   <= 1'b0;
      arvalid_q  <= 1'b0;
      rready_q   <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
    end else if (abort_d) begin
      state_q    <= ST_DONE;
      tmo_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b1;
      err_q      <= 1'b1;
      err_code_q <= code_d;
      err_idx_q  <= idx_q;
      awvalid_q  <= 1'b0;
      wvalid_q   <= 1'b0;
      bready_q   <= 1'b0;
      arvalid_q  <= 1'b0;
      rready_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: if (start_i) begin
          state_q    <= ST_WR;
          tmo_q      <= '0;
          idx_q      <= '0;
          busy_q     <= 1'b1;
          err_q      <= 1'b0;
          err_code_q <= SEQ_OK;
          err_idx_q  <= '0;
          awvalid_q  <= 1'b1;
          wvalid_q   <= 1'b1;
          addr_q     <= addr_tbl[0];
          wdata_q    <= data_tbl[0];
        end
        ST_WR: begin
          if (aw_done_d && w_done_d) begin
            state_q   <= ST_B;
            tmo_q     <= '0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b1;
          end else begin
            tmo_q <= tmo_d;
            if (awready_i) awvalid_q <= 1'b0;
            if (wready_i)  wvalid_q  <= 1'b0;
          end
        end
        ST_B: begin
          if (bvalid_i) begin
            state_q   <= ST_AR;
            tmo_q     <= '0;
            bready_q  <= 1'b0;
            arvalid_q <= 1'b1;
          end else begin
            tmo_q <= tmo_d;
          end
        end
        ST_AR: begin
          if (arready_i) begin
            state_q   <= ST_R;
            tmo_q     <= '0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
          end else begin
            tmo_q <= tmo_d;
          end
        end
        ST_R: begin
          if (rvalid_i) begin
            tmo_q    <= '0;
            rready_q <= 1'b0;
            if (idx_q == IDX_LAST) begin
              state_q <= ST_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              state_q   <= ST_WR;
              idx_q     <= idx_d;
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
              addr_q    <= addr_tbl[idx_d];
              wdata_q   <= data_tbl[idx_d];
            end
          end else begin
            tmo_q <= tmo_d;
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign err_o      = err_q;
  assign err_code_o = err_code_q;
  assign err_idx_o  = err_idx_q;
  assign awaddr_o   = addr_q;
  assign awvalid_o  = awvalid_q;
  assign wdata_o    = wdata_q;
  assign wstrb_o    = WSTRB_FULL;
  assign wlast_o    = 1'b1;
  assign wvalid_o   = wvalid_q;
  assign bready_o   = bready_q;
  assign araddr_o   = addr_q;
  assign arvalid_o  = arvalid_q;
  assign rready_o   = rready_q;

endmodule

// File: tb/tb_axi_reg_cfg_seq.sv
// Bench for axi_reg_cfg_seq: a behavioural 6-register AXI slave with
// programmable ready latency and fault injection, plus a run scoreboard.
module tb_axi_reg_cfg_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        areset = 1'b1;
  logic        start = 1'b0;
  logic        busy_o, done_o, err_o, awvalid_o, wvalid_o, wlast_o, bready_o, arvalid_o, rready_o;
  logic [1:0]  err_code_o;
  logic [3:0]  err_idx_o, wstrb_o;
  logic [31:0] awaddr_o, wdata_o, araddr_o;
  logic        awready, wready, arready;
  logic        bvalid, rvalid;
  logic [1:0]  bresp;
  logic [31:0] rdata;

  axi_reg_cfg_seq dut (
    .clk        (clk),
    .areset     (areset),
    .start_i    (start),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .err_o      (err_o),
    .err_code_o (err_code_o),
    .err_idx_o  (err_idx_o),
    .awaddr_o   (awaddr_o),
    .awvalid_o  (awvalid_o),
    .awready_i  (awready),
    .wdata_o    (wdata_o),
    .wstrb_o    (wstrb_o),
    .wlast_o    (wlast_o),
    .wvalid_o   (wvalid_o),
    .wready_i   (wready),
    .bresp_i    (bresp),
    .bvalid_i   (bvalid),
    .bready_o   (bready_o),
    .araddr_o   (araddr_o),
    .arvalid_o  (arvalid_o),
    .arready_i  (arready),
    .rdata_i    (rdata),
    .rvalid_i   (rvalid),
    .rready_o   (rready_o)
  );

  // Slave knobs, set by the test before each run
  int   aw_lat = 0, w_lat = 0, berr_on = -1, rbad_on = -1;
  logic sl_clr = 1'b0;

  logic [31:0] mem [8];
  int          aw_cnt, w_cnt, wr_count, rd_count;
  logic        aw_got, w_got;
  logic [31:0] aw_addr_l, w_data_l;
  logic        aw_fire, w_fire, ar_fire, wr_complete;
  logic [31:0] wr_addr, wr_data;

  assign awready     = awvalid_o && (aw_cnt >= aw_lat);
  assign wready      = wvalid_o && (w_cnt >= w_lat);
  assign arready     = arvalid_o;
  assign aw_fire     = awvalid_o && awready;
  assign w_fire      = wvalid_o && wready;
  assign ar_fire     = arvalid_o && arready;
  assign wr_complete = (aw_got || aw_fire) && (w_got || w_fire);
  assign wr_addr     = aw_got ? aw_addr_l : awaddr_o;
  assign wr_data     = w_got ? w_data_l : wdata_o;

  always @(posedge clk or posedge areset) begin
    if (areset) begin
      bvalid <= 1'b0; rvalid <= 1'b0; bresp <= 2'b00; rdata <= '0;
      aw_got <= 1'b0; w_got <= 1'b0; aw_cnt <= 0; w_cnt <= 0;
    end else if (sl_clr) begin
      bvalid <= 1'b0; rvalid <= 1'b0; bresp <= 2'b00; rdata <= '0;
      aw_got <= 1'b0; w_got <= 1'b0; aw_cnt <= 0; w_cnt <= 0;
      wr_count <= 0; rd_count <= 0;
      for (int i = 0; i < 8; i++) mem[i] <= '0;
    end else begin
      aw_cnt <= (awvalid_o && !awready) ? aw_cnt + 1 : 0;
      w_cnt  <= (wvalid_o && !wready) ? w_cnt + 1 : 0;
      if (wr_complete) begin
        aw_got   <= 1'b0;
        w_got    <= 1'b0;
        bvalid   <= 1'b1;
        bresp    <= (wr_count == berr_on) ? 2'b10 : 2'b00;
        if (wr_count != berr_on && wr_addr < 32'd24) mem[wr_addr[4:2]] <= wr_data;
        wr_count <= wr_count + 1;
      end else begin
        if (aw_fire) begin aw_got <= 1'b1; aw_addr_l <= awaddr_o; end
        if (w_fire)  begin w_got  <= 1'b1; w_data_l  <= wdata_o;  end
      end
      if (bvalid && bready_o) bvalid <= 1'b0;
      if (rvalid && rready_o) begin
        rvalid <= 1'b0;
      end else if (ar_fire) begin
        rvalid   <= 1'b1;
        rdata    <= (rd_count == rbad_on) ? 32'hDEAD :
                    (araddr_o < 32'd24) ? mem[araddr_o[4:2]] : 32'h0;
        rd_count <= rd_count + 1;
      end
    end
  end

  // Per-run activity counters: cycles busy and cycles each write valid was up
  int busy_cnt, aw_hi, w_hi;
  always @(posedge clk) begin
    if (sl_clr) begin
      busy_cnt <= 0; aw_hi <= 0; w_hi <= 0;
    end else begin
      busy_cnt <= busy_cnt + int'(busy_o);
      aw_hi    <= aw_hi + int'(awvalid_o);
      w_hi     <= w_hi + int'(wvalid_o);
    end
  end

  typedef struct {
    int              aw_lat, w_lat, berr_on, rbad_on;
    bit              extra_start;
    logic            err;
    logic [1:0]      code;
    logic [3:0]      idx;
    int              cycles, aw_hi, w_hi;
    logic [3:0][31:0] mem;
  } vec_t;

  function automatic vec_t mk(input int awl, input int wl, input int be, input int rb,
                              input logic er, input logic [1:0] cd, input logic [3:0] ix,
                              input int cy, input int ah, input int wh, input logic [127:0] m);
    vec_t v;
    v.aw_lat = awl; v.w_lat = wl; v.berr_on = be; v.rbad_on = rb; v.extra_start = 1'b0;
    v.err = er; v.code = cd; v.idx = ix; v.cycles = cy; v.aw_hi = ah; v.w_hi = wh;
    v.mem = m;
    return v;
  endfunction

  int   n_vec = 0, n_mis = 0, run_no = 0;
  vec_t exp_q[$];
  vec_t vecs[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v);
    vec_t e;
    bit   got;
    @(negedge clk);
    aw_lat = v.aw_lat; w_lat = v.w_lat; berr_on = v.berr_on; rbad_on = v.rbad_on;
    sl_clr = 1'b1;
    @(negedge clk);
    sl_clr = 1'b0;
    start  = 1'b1;
    exp_q.push_back(v);
    @(negedge clk);
    start = 1'b0;
    if (v.extra_start) begin
      repeat (4) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    got = 1'b0;
    for (int k = 0; k < 300 && !got; k++) begin
      @(negedge clk);
      if (done_o) got = 1'b1;
    end
    chk("done_seen", 32'(got), 32'd1);
    if (exp_q.size() == 0) begin
      chk("scoreboard_empty", 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      $display("run %0d: err=%0d code=%0d idx=%0d busy_cycles=%0d aw_hi=%0d w_hi=%0d",
               run_no, err_o, err_code_o, err_idx_o, busy_cnt, aw_hi, w_hi);
      chk("err", 32'(err_o), 32'(e.err));
      chk("err_code", 32'(err_code_o), 32'(e.code));
      chk("err_idx", 32'(err_idx_o), 32'(e.idx));
      chk("busy_cycles", busy_cnt, e.cycles);
      chk("awvalid_cycles", aw_hi, e.aw_hi);
      chk("wvalid_cycles", w_hi, e.w_hi);
      for (int r = 0; r < 4; r++) chk($sformatf("reg%0d", r), mem[r], e.mem[r]);
      chk("busy_at_done", 32'(busy_o), 32'd0);
      chk("awvalid_at_done", 32'(awvalid_o), 32'd0);
      @(negedge clk);
      chk("done_pulse_width", 32'(done_o), 32'd0);
      chk("err_sticky", 32'(err_o), 32'(e.err));
      chk("busy_after_done", 32'(busy_o), 32'd0);
    end
    run_no++;
  endtask

  initial begin
    vec_t v6;
    bit   got;

    //        awl wl  be  rb  err code  idx  cyc awh wh  registers 3..0
    vecs[0] = mk(0, 0, -1, -1, 1'b0, 2'd0, 4'd0, 16, 4, 4, {32'd4, 32'd3, 32'd2, 32'd1});
    vecs[1] = mk(0, 0, 2, -1, 1'b1, 2'd1, 4'd2, 10, 3, 3, {32'd0, 32'd0, 32'd2, 32'd1});
    vecs[2] = mk(0, 0, -1, 1, 1'b1, 2'd2, 4'd1, 8, 2, 2, {32'd0, 32'd0, 32'd2, 32'd1});
    vecs[3] = mk(20, 0, -1, -1, 1'b1, 2'd3, 4'd0, 16, 16, 1, {32'd0, 32'd0, 32'd0, 32'd0});
    vecs[4] = mk(3, 1, -1, -1, 1'b0, 2'd0, 4'd0, 28, 16, 8, {32'd4, 32'd3, 32'd2, 32'd1});

    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_done", 32'(done_o), 32'd0);
    chk("rst_err", 32'(err_o), 32'd0);
    chk("rst_awvalid", 32'(awvalid_o), 32'd0);
    chk("rst_wvalid", 32'(wvalid_o), 32'd0);
    chk("rst_arvalid", 32'(arvalid_o), 32'd0);
    chk("wstrb", 32'(wstrb_o), 32'hF);
    chk("wlast", 32'(wlast_o), 32'd1);
    areset = 1'b0;

    for (int i = 0; i < 5; i++) run_vec(vecs[i]);

    // Asynchronous reset in the read-data phase of entry 1
    @(negedge clk);
    aw_lat = 0; w_lat = 0; berr_on = -1; rbad_on = -1;
    sl_clr = 1'b1;
    @(negedge clk);
    sl_clr = 1'b0;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 100 && !got; k++) begin
      if (rready_o && araddr_o == 32'h4) got = 1'b1;
      else @(negedge clk);
    end
    chk("reach_r_entry1", 32'(got), 32'd1);
    areset = 1'b1;
    #1;
    chk("arst_busy", 32'(busy_o), 32'd0);
    chk("arst_rready", 32'(rready_o), 32'd0);
    chk("arst_bready", 32'(bready_o), 32'd0);
    chk("arst_arvalid", 32'(arvalid_o), 32'd0);
    chk("arst_awaddr", awaddr_o, 32'd0);
    chk("arst_err_code", 32'(err_code_o), 32'd0);
    @(negedge clk);
    areset = 1'b0;

    // Clean rerun with a stray start pulse in the middle
    v6 = vecs[0];
    v6.extra_start = 1'b1;
    run_vec(v6);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
